// File: rtl/spu32_cpu_mulctl.sv
// Multiply sequencer for the M extension: issues operands to the DSP multiplier, waits for it,
// selects the architectural 32-bit result and keeps a one-entry product cache for MULH/MUL pairs.
module spu32_cpu_mulctl #(
    parameter bit          CACHE_EN = 1'b1,
    parameter int unsigned MIN_WAIT = 0
) (
    input  logic        I_clk,
    input  logic        I_reset,
    input  logic        I_en,
    input  logic [3:0]  I_op,
    input  logic [31:0] I_s1,
    input  logic [31:0] I_s2,
    output logic [3:0]  O_mul_op,
    output logic [31:0] O_mul_s1,
    output logic [31:0] O_mul_s2,
    input  logic [63:0] I_mul_result,
    input  logic        I_mul_busy,
    output logic [31:0] O_result,
    output logic        O_valid,
    output logic        O_busy
);

    localparam logic [3:0] ALUOP_MUL    = 4'b1010;
    localparam logic [3:0] ALUOP_MULH   = 4'b1011;
    localparam logic [3:0] ALUOP_MULHSU = 4'b1100;
    localparam logic [3:0] ALUOP_MULHU  = 4'b1101;
    localparam logic [2:0] WAIT_CYCLES  = 3'(MIN_WAIT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {CLS_UU, CLS_SU, CLS_SS} mul_class_t;

    // Handshake: I_en is taken only while O_busy is low (IDLE or DONE); O_valid pulses one
    // cycle with O_result, and O_result then holds until the next accepted op completes.
    state_t     state;
    logic [2:0] wait_cnt;

    logic        cache_valid;
    logic [31:0] cache_s1;
    logic [31:0] cache_s2;
    mul_class_t  cache_cls;
    logic [63:0] cache_prod;

    function automatic logic is_mul(input logic [3:0] op);
        return (op == ALUOP_MUL) || (op == ALUOP_MULH) ||
               (op == ALUOP_MULHSU) || (op == ALUOP_MULHU);
    endfunction

    function automatic mul_class_t class_of(input logic [3:0] op);
        if (op == ALUOP_MULH)
            return CLS_SS;
        else if (op == ALUOP_MULHSU)
            return CLS_SU;
        else
            return CLS_UU;
    endfunction

    function automatic logic [31:0] select_word(input logic [3:0] op, input logic [63:0] prod);
        return (op == ALUOP_MUL) ? prod[31:0] : prod[63:32];
    endfunction

    // The low product word does not depend on signedness, so MUL hits on any cached class.
    logic cache_hit;
    always_comb begin
        cache_hit = CACHE_EN && cache_valid && (I_s1 == cache_s1) && (I_s2 == cache_s2) &&
                    ((I_op == ALUOP_MUL) || (class_of(I_op) == cache_cls));
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state       <= S_IDLE;
            wait_cnt    <= 3'd0;
            O_mul_op    <= 4'd0;
            O_mul_s1    <= 32'd0;
            O_mul_s2    <= 32'd0;
            O_result    <= 32'd0;
            O_valid     <= 1'b0;
            O_busy      <= 1'b0;
            cache_valid <= 1'b0;
            cache_s1    <= 32'd0;
            cache_s2    <= 32'd0;
            cache_cls   <= CLS_UU;
            cache_prod  <= 64'd0;
        end else begin
            O_valid <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    if (I_en) begin
                        if (!is_mul(I_op)) begin
                            O_mul_op <= I_op;
                            O_mul_s1 <= I_s1;
                            O_mul_s2 <= I_s2;
                            O_result <= 32'd0;
                            O_valid  <= 1'b1;
                            state    <= S_DONE;
                        end else if (cache_hit) begin
                            O_result <= select_word(I_op, cache_prod);
                            O_valid  <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            O_mul_op <= I_op;
                            O_mul_s1 <= I_s1;
                            O_mul_s2 <= I_s2;
                            O_busy   <= 1'b1;
                            wait_cnt <= WAIT_CYCLES;
                            state    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt != 3'd0) begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end else if (!I_mul_busy) begin
                        cache_valid <= 1'b1;
                        cache_s1    <= O_mul_s1;
                        cache_s2    <= O_mul_s2;
                        cache_cls   <= class_of(O_mul_op);
                        cache_prod  <= I_mul_result;
                        O_result    <= select_word(O_mul_op, I_mul_result);
                        O_valid     <= 1'b1;
                        O_busy      <= 1'b0;
                        state       <= S_DONE;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    O_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spu32_cpu_mulctl.sv
// Bench for spu32_cpu_mulctl: directed scenarios plus randomized ops against a behavioural
// product/cache model; dut_a uses default parameters, dut_b has no cache and MIN_WAIT=2.
module tb_spu32_cpu_mulctl;

    localparam logic [3:0] OP_MUL    = 4'b1010;
    localparam logic [3:0] OP_MULH   = 4'b1011;
    localparam logic [3:0] OP_MULHSU = 4'b1100;
    localparam logic [3:0] OP_MULHU  = 4'b1101;
    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_OR     = 4'b0011;
    localparam logic [63:0] JUNK     = 64'h0123_4567_89AB_CDEF;
    localparam int MIN_WAIT_B        = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        sel = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] s1 = 32'd0;
    logic [31:0] s2 = 32'd0;
    logic        mul_busy = 1'b0;

    logic        en_a, en_b;
    logic [3:0]  mop_a, mop_b;
    logic [31:0] ms1_a, ms1_b, ms2_a, ms2_b;
    logic [63:0] mres_a, mres_b;
    logic [31:0] res_a, res_b;
    logic        valid_a, valid_b, busy_a, busy_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state: one cached operand pair for dut_a plus expected multiplier regs.
    bit          m_valid;
    logic [31:0] m_s1, m_s2;
    bit          m_sa, m_sb;
    logic [3:0]  exp_mop[2];
    logic [31:0] exp_ms1[2];
    logic [31:0] exp_ms2[2];

    always #5 clk = ~clk;

    assign en_a = en & ~sel;
    assign en_b = en & sel;

    function automatic logic [63:0] ref_prod(input logic [3:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] x, y;
        x = (o == OP_MULH || o == OP_MULHSU) ? {{32{a[31]}}, a} : {32'd0, a};
        y = (o == OP_MULH) ? {{32{b[31]}}, b} : {32'd0, b};
        return x * y;
    endfunction

    function automatic bit ref_is_mul(input logic [3:0] o);
        return o == OP_MUL || o == OP_MULH || o == OP_MULHSU || o == OP_MULHU;
    endfunction

    // Single-cycle DSP model; anything sampled outside a valid window is junk.
    always_comb begin
        mres_a = (busy_a && !mul_busy) ? ref_prod(mop_a, ms1_a, ms2_a) : JUNK;
        mres_b = (busy_b && !mul_busy) ? ref_prod(mop_b, ms1_b, ms2_b) : JUNK;
    end

    spu32_cpu_mulctl dut_a (
        .I_clk(clk), .I_reset(rst), .I_en(en_a), .I_op(op), .I_s1(s1), .I_s2(s2),
        .O_mul_op(mop_a), .O_mul_s1(ms1_a), .O_mul_s2(ms2_a),
        .I_mul_result(mres_a), .I_mul_busy(mul_busy),
        .O_result(res_a), .O_valid(valid_a), .O_busy(busy_a)
    );

    spu32_cpu_mulctl #(.CACHE_EN(1'b0), .MIN_WAIT(MIN_WAIT_B)) dut_b (
        .I_clk(clk), .I_reset(rst), .I_en(en_b), .I_op(op), .I_s1(s1), .I_s2(s2),
        .O_mul_op(mop_b), .O_mul_s1(ms1_b), .O_mul_s2(ms2_b),
        .I_mul_result(mres_b), .I_mul_busy(mul_busy),
        .O_result(res_b), .O_valid(valid_b), .O_busy(busy_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_mul_regs(input string tag);
        chk({tag, "_mop"}, sel ? mop_b : mop_a, exp_mop[sel]);
        chk({tag, "_ms1"}, sel ? ms1_b : ms1_a, exp_ms1[sel]);
        chk({tag, "_ms2"}, sel ? ms2_b : ms2_a, exp_ms2[sel]);
    endtask

    task automatic model_reset();
        m_valid = 0;
        for (int i = 0; i < 2; i++) begin
            exp_mop[i] = 4'd0;
            exp_ms1[i] = 32'd0;
            exp_ms2[i] = 32'd0;
        end
    endtask

    // Issue one op on the selected DUT (called right after an edge, DUT not busy) and follow it
    // to its O_valid cycle. busy_cyc = WAIT edges on which the multiplier reports busy.
    task automatic run_op(input bit which, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int busy_cyc, input bit poke);
        bit          hit, miss;
        int          lat, mw;
        logic [31:0] er;
        logic [63:0] p;
        mw  = which ? MIN_WAIT_B : 0;
        hit = 0;
        if (!which && ref_is_mul(o) && m_valid && a == m_s1 && b == m_s2)
            hit = (o == OP_MUL) ||
                  (m_sa == (o == OP_MULH || o == OP_MULHSU) && m_sb == (o == OP_MULH));
        miss = ref_is_mul(o) && !hit;
        p    = ref_prod(o, a, b);
        er   = !ref_is_mul(o) ? 32'd0 : (o == OP_MUL) ? p[31:0] : p[63:32];
        lat  = miss ? 2 + ((mw > busy_cyc) ? mw : busy_cyc) : 1;
        if (!hit) begin
            exp_mop[which] = o;
            exp_ms1[which] = a;
            exp_ms2[which] = b;
        end
        if (miss && !which) begin
            m_valid = 1;
            m_s1    = a;
            m_s2    = b;
            m_sa    = (o == OP_MULH || o == OP_MULHSU);
            m_sb    = (o == OP_MULH);
        end
        sel      = which;
        op       = o;
        s1       = a;
        s2       = b;
        mul_busy = (busy_cyc > 0);
        en       = 1'b1;
        for (int c = 1; c <= lat; c++) begin
            @(posedge clk);
            #1;
            mul_busy = (c <= busy_cyc);
            if (c == 1) begin
                en = poke && (lat >= 3);
                if (en) begin
                    op = OP_MULH;
                    s1 = $urandom;
                end
                chk_mul_regs("accept");
            end else begin
                en = 1'b0;
            end
            if (c < lat) begin
                chk("valid_early", sel ? valid_b : valid_a, 1'b0);
                chk("busy_wait", sel ? busy_b : busy_a, miss);
            end else begin
                chk("valid", sel ? valid_b : valid_a, 1'b1);
                chk("busy_done", sel ? busy_b : busy_a, 1'b0);
                chk("result", sel ? res_b : res_a, er);
            end
        end
        if (miss) chk_mul_regs("capture");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pool[4];
        logic [3:0]  ops[6];
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", res_a, 32'd0);
        chk("rst_valid", valid_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_b_valid", valid_b, 1'b0);
        chk_mul_regs("rst");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Cache hit / class mismatch sequence on all-ones operands.
        run_op(0, OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        chk("t1_value", res_a, 32'hFFFF_FFFE);
        run_op(0, OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        chk("t2_value", res_a, 32'h0000_0001);
        run_op(0, OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        chk("t3_mulh", res_a, 32'h0000_0000);
        run_op(0, OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        chk("t3_mulhsu", res_a, 32'hFFFF_FFFF);

        // Multiplier busy for 4 cycles with an ignored I_en during WAIT.
        run_op(0, OP_MULHU, 32'h0001_0000, 32'h0001_0000, 4, 1);
        chk("t4_value", res_a, 32'h0000_0001);
        @(posedge clk);
        #1;
        chk("t4_no_second", valid_a, 1'b0);
        chk("t4_idle_busy", busy_a, 1'b0);

        // Reset during WAIT aborts the op and empties the cache.
        sel = 0; op = OP_MULHU; s1 = 32'h1234_5678; s2 = 32'h9ABC_DEF0; mul_busy = 1'b1;
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mul_busy = 1'b0;
        model_reset();
        chk("t5_valid", valid_a, 1'b0);
        chk("t5_busy", busy_a, 1'b0);
        chk("t5_result", res_a, 32'd0);
        chk_mul_regs("t5");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("t5_quiet", valid_a, 1'b0);
        end
        run_op(0, OP_MULHU, 32'h0001_0000, 32'h0001_0000, 0, 0);

        // No cache: identical ops both miss; non-mul completes in one cycle.
        run_op(1, OP_MUL, 32'd3, 32'd5, 0, 0);
        chk("t6_first", res_b, 32'h0000_000F);
        run_op(1, OP_MUL, 32'd3, 32'd5, 0, 0);
        chk("t6_second", res_b, 32'h0000_000F);
        run_op(1, OP_ADD, 32'd3, 32'd5, 0, 0);
        run_op(0, OP_OR, 32'd7, 32'd9, 0, 0);

        // Randomized back-to-back traffic from a small operand pool to provoke hits.
        ops = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_ADD, OP_OR};
        pool = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0007, $urandom};
        for (int i = 0; i < 120; i++) begin
            if (i % 16 == 0) pool[3] = $urandom;
            run_op((i >= 90), ops[$urandom_range(0, 5)], pool[$urandom_range(0, 3)],
                   pool[$urandom_range(0, 3)], $urandom_range(0, 3), $urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
                chk("gap_quiet", sel ? valid_b : valid_a, 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
